// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam logic MODE_PULSE = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/clk_div_counter.sv
// Enabled mod-N counter with synchronous clear and terminal-count flag.
module clk_div_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_d_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign tc_o = (count_q == (div_i - WIDTH'(1)));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + WIDTH'(1);
        end
    end

    // Synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/clk_divider_prog.sv
// Programmable clock divider: pulse/level output, divisor handshake applied at period end.
module clk_divider_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 7
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clk_en,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_mode,
    input  logic             i_div_valid,
    input  logic [WIDTH-1:0] i_div_value,
    output logic             o_div_ready,
    output logic             o_div_err,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             stop_q, stop_d;
    logic             err_q, err_d;
    logic             div_clk_q, div_clk_d;

    logic [WIDTH-1:0] count, count_d;
    logic             tc_raw, tick, boundary, accept, legal, apply;
    logic [WIDTH:0]   half;

    clk_div_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .clr_i     (state_q == StIdle),
        .en_i      ((state_q == StRun) && i_clk_en),
        .div_i     (div_q),
        .count_o   (count),
        .count_d_o (count_d),
        .tc_o      (tc_raw)
    );

    assign tick     = (state_q == StRun) && tc_raw;
    assign boundary = tick && i_clk_en;
    assign accept   = i_div_valid && !pend_q;
    assign legal    = (i_div_value >= WIDTH'(MIN_DIV));
    assign apply    = (state_q == StIdle) || boundary;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            mode_q     <= MODE_PULSE;
            div_q      <= WIDTH'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            stop_q     <= 1'b0;
            err_q      <= 1'b0;
            div_clk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            stop_q     <= stop_d;
            err_q      <= err_d;
            div_clk_q  <= div_clk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        stop_d     = 1'b0;
        err_d      = accept && !legal;

        unique case (state_q)
            StIdle: if (i_start) state_d = StRun;
            StRun: begin
                stop_d = (stop_q || i_stop) && !boundary;
                if (boundary && (stop_q || i_stop)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Only a divisor already pending before this cycle may take effect now.
        if (apply) begin
            mode_d = i_mode;
            if (pend_q) begin
                div_d  = pend_val_q;
                pend_d = 1'b0;
            end
        end

        if (accept && legal) begin
            pend_d     = 1'b1;
            pend_val_d = i_div_value;
        end
    end

    // Output is a function of next-cycle state so the registered copy lines up with o_count.
    always_comb begin
        half      = ({1'b0, div_d} + (WIDTH + 1)'(1)) >> 1;
        div_clk_d = 1'b0;
        if (state_d == StRun) begin
            if (mode_d == MODE_LEVEL) begin
                div_clk_d = ({1'b0, count_d} < half);
            end else begin
                div_clk_d = (count_d == (div_d - WIDTH'(1)));
            end
        end
    end

    assign o_div_ready = !pend_q;
    assign o_div_err   = err_q;
    assign o_div_clk   = div_clk_q;
    assign o_tick      = tick;
    assign o_count     = count;
    assign o_busy      = (state_q == StRun);

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench: per-cycle expectations from a period-level reference model.
module tb_clk_divider_prog;

    logic       clk = 1'b0;
    logic       resetn, i_clk_en, i_start, i_stop, i_mode, i_div_valid;
    logic [7:0] i_div_value;
    logic       o_div_ready, o_div_err, o_div_clk, o_tick, o_busy;
    logic [7:0] o_count;

    always #5 clk = ~clk;

    clk_divider_prog #(
        .WIDTH       (8),
        .DEFAULT_DIV (7)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_clk_en    (i_clk_en),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .i_div_valid (i_div_valid),
        .i_div_value (i_div_value),
        .o_div_ready (o_div_ready),
        .o_div_err   (o_div_err),
        .o_div_clk   (o_div_clk),
        .o_tick      (o_tick),
        .o_count     (o_count),
        .o_busy      (o_busy)
    );

    typedef struct {
        bit dclk;
        bit tick;
        bit busy;
        bit ready;
        bit err;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: position within the period, active divisor, latched mode, pending items.
    bit m_run, m_mode, m_pend, m_stop, m_err;
    int m_cnt, m_n, m_pval;

    function automatic void model_step();
        bit acc, at_end;
        acc = i_div_valid && !m_pend;
        if (!resetn) begin
            m_run = 0; m_cnt = 0; m_n = 7; m_mode = 0;
            m_pend = 0; m_stop = 0; m_err = 0; m_pval = 0;
            return;
        end
        m_err  = acc && (i_div_value < 2);
        at_end = m_run && i_clk_en && (m_cnt == m_n - 1);
        if (!m_run) begin
            m_cnt  = 0;
            m_mode = i_mode;
            m_stop = 0;
            if (m_pend) begin m_n = m_pval; m_pend = 0; end
            if (i_start) m_run = 1;
        end else begin
            if (i_stop) m_stop = 1;
            if (at_end) begin
                m_cnt  = 0;
                m_mode = i_mode;
                if (m_pend) begin m_n = m_pval; m_pend = 0; end
                if (m_stop) begin m_run = 0; m_stop = 0; end
            end else if (i_clk_en) begin
                m_cnt++;
            end
        end
        if (acc && i_div_value >= 2) begin
            m_pend = 1;
            m_pval = i_div_value;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t r;
        r.cnt   = m_cnt;
        r.busy  = m_run;
        r.tick  = m_run && (m_cnt == m_n - 1);
        r.dclk  = m_run && (m_mode ? (m_cnt < (m_n + 1) / 2) : (m_cnt == m_n - 1));
        r.ready = !m_pend;
        r.err   = m_err;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, want);
        end
    endtask

    // Monitor: outputs settle just after the edge; inputs change only on the falling edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("o_div_clk",   {31'd0, o_div_clk},   {31'd0, e.dclk});
            chk("o_tick",      {31'd0, o_tick},      {31'd0, e.tick});
            chk("o_busy",      {31'd0, o_busy},      {31'd0, e.busy});
            chk("o_div_ready", {31'd0, o_div_ready}, {31'd0, e.ready});
            chk("o_div_err",   {31'd0, o_div_err},   {31'd0, e.err});
            chk("o_count",     {24'd0, o_count},     e.cnt);
        end
    end

    task automatic cyc(input bit st, input bit sp, input bit dv, input int v);
        i_start     = st;
        i_stop      = sp;
        i_div_valid = dv;
        i_div_value = 8'(v);
        model_step();
        q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0);
    endtask

    task automatic wait_cnt(input int c);
        for (int k = 0; k < 600 && !(m_run && m_cnt == c); k++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        int r, v;
        resetn = 0; i_clk_en = 1; i_mode = 0;
        idle(2);
        resetn = 1;

        // Level mode at default divisor 7: 4 high / 3 low.
        i_mode = 1;
        cyc(1, 0, 0, 0);
        idle(16);

        // Illegal divisor rejected.
        wait_cnt(2); cyc(0, 0, 1, 1);
        idle(14);

        // N=4 written mid-period; second write sees ready low.
        wait_cnt(2); cyc(0, 0, 1, 4); cyc(0, 0, 1, 9);
        idle(16);
        wait_cnt(0); cyc(0, 0, 1, 7);
        idle(10);

        // Enable low for 5 cycles at count 3.
        wait_cnt(3); i_clk_en = 0; idle(5); i_clk_en = 1;
        idle(14);

        // Stop at count 1 runs to period end.
        wait_cnt(1); cyc(0, 1, 0, 0);
        idle(10);

        // Reset mid-period with a divisor pending.
        cyc(1, 0, 0, 0);
        wait_cnt(3); cyc(0, 0, 1, 9);
        wait_cnt(5); resetn = 0; idle(1); resetn = 1;
        cyc(1, 0, 0, 0);
        idle(16);

        for (int k = 0; k < 3000; k++) begin
            resetn = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 9) == 0) i_mode = 1'($urandom_range(0, 1));
            i_clk_en = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 15);
            v = (r < 2) ? r : (r == 15) ? $urandom_range(200, 255) : r;
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 5) == 0, v);
        end

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
